// File: rtl/csd2bin_seq.sv
// csd2bin_seq -- iterative canonical-signed-digit to two's-complement converter.
//
// Accepts a W-digit signed-digit word (from bkm_step) and resolves the borrow
// chain serially, DPC digits per cycle, so the design never needs a W-bit
// carry-propagate subtract in a single cycle. Results go to the FPU output
// stage through a valid/ready handshake.
//
// Optional feature macro: CSD2BIN_SEQ_CSD_CHECK_EN
//   When defined, adds output csd_err, flagging a non-canonical input word
//   (a digit coded 11, or two adjacent nonzero digits). Arithmetic is unchanged.
//
// Ports:
//   clk        clock
//   arst       asynchronous active-high reset
//   srst       synchronous active-high reset (same effect as arst)
//   enable     global advance/stall qualifier; every register holds while low
//   in_valid   source has a CSD word
//   in_ready   block can accept a word (idle and enabled)
//   x_csd      2*W bits, digit i = {x_csd[2i+1]=pos, x_csd[2i]=neg}
//   out_valid  result available (done and enabled)
//   out_ready  sink accepts the result
//   y          W-bit two's-complement result, X mod 2^W
//   ovf        X lies outside the signed W-bit range
//   csd_err    (optional) input word was not canonical
//
// Assumes DPC divides W and DPC < W.
module csd2bin_seq #(
    parameter int W     = 8,
    parameter int DPC   = 2,
    parameter int LOG2W = 3
) (
    input  logic           clk,
    input  logic           arst,
    input  logic           srst,
    input  logic           enable,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] x_csd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   y,
    output logic           ovf
`ifdef CSD2BIN_SEQ_CSD_CHECK_EN
    ,
    output logic           csd_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [W-1:0]       r_p;        // remaining positive digit bits
    logic [W-1:0]       r_n;        // remaining negative digit bits
    logic               r_borrow;
    logic [LOG2W-1:0]   r_cnt;
    logic [W-DPC-1:0]   r_acc;      // result slices gathered so far (MSB-justified)
    logic [W-1:0]       r_y;
    logic               r_ovf;

    logic [W-1:0]       w_pos;
    logic [W-1:0]       w_neg;
    logic [DPC:0]       w_diff;     // slice difference, MSB is the borrow-out
    logic [W-1:0]       w_cat;      // accumulator with the current slice on top
    logic               w_last;
    logic               w_in_xfer;
    logic               w_out_xfer;

    // Split the digit vector into positive and negative bit planes.
    always_comb begin
        w_pos = '0;
        w_neg = '0;
        for (int i = 0; i < W; i++) begin
            w_pos[i] = x_csd[2*i+1];
            w_neg[i] = x_csd[2*i];
        end
    end

    assign in_ready   = enable & (r_state == IDLE);
    assign out_valid  = enable & (r_state == DONE);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // Digit code 11 naturally contributes 1 - 1 = 0 here.
    assign w_diff = {1'b0, r_p[DPC-1:0]} - {1'b0, r_n[DPC-1:0]}
                    - {{DPC{1'b0}}, r_borrow};
    assign w_cat  = {w_diff[DPC-1:0], r_acc};
    assign w_last = (r_cnt == LOG2W'(W/DPC - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_in_xfer)         w_state_nxt = CONV;
            CONV:    if (enable && w_last)  w_state_nxt = DONE;
            DONE:    if (w_out_xfer)        w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
        end else if (srst) begin
            r_state <= IDLE;
        end else if (enable) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_p      <= '0;
            r_n      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_y      <= '0;
            r_ovf    <= 1'b0;
        end else if (srst) begin
            r_p      <= '0;
            r_n      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_y      <= '0;
            r_ovf    <= 1'b0;
        end else if (enable) begin
            if (r_state == IDLE && w_in_xfer) begin
                r_p      <= w_pos;
                r_n      <= w_neg;
                r_borrow <= 1'b0;
                r_cnt    <= '0;
                r_acc    <= '0;
            end else if (r_state == CONV) begin
                r_p      <= r_p >> DPC;
                r_n      <= r_n >> DPC;
                r_borrow <= w_diff[DPC];
                r_cnt    <= r_cnt + LOG2W'(1);
                r_acc    <= w_cat[W-1:DPC];
                // Output registers only move when a conversion completes.
                // The final borrow is bit W of the (W+1)-bit difference;
                // overflow when it disagrees with the result sign bit.
                if (w_last) begin
                    r_y   <= w_cat;
                    r_ovf <= w_diff[DPC] ^ w_diff[DPC-1];
                end
            end
        end
    end

    assign y   = r_y;
    assign ovf = r_ovf;

`ifdef CSD2BIN_SEQ_CSD_CHECK_EN
    logic r_csd_err;
    logic w_nz_any;
    logic w_err;

    // Non-canonical: a digit coded 11, or two neighbouring nonzero digits.
    assign w_nz_any = |((w_pos | w_neg) & ((w_pos | w_neg) >> 1));
    assign w_err    = (|(w_pos & w_neg)) | w_nz_any;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_csd_err <= 1'b0;
        end else if (srst) begin
            r_csd_err <= 1'b0;
        end else if (enable && r_state == IDLE && w_in_xfer) begin
            r_csd_err <= w_err;
        end
    end

    assign csd_err = r_csd_err;
`endif

endmodule

// File: tb/tb_csd2bin_seq.sv
// Directed and random bench for csd2bin_seq (W=8, DPC=2).
module tb_csd2bin_seq;

    logic        clk = 1'b0;
    logic        arst;
    logic        srst;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_csd;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;
    logic        ovf;
`ifdef CSD2BIN_SEQ_CSD_CHECK_EN
    logic        csd_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    csd2bin_seq #(.W(8), .DPC(2), .LOG2W(3)) dut (
        .clk       (clk),
        .arst      (arst),
        .srst      (srst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_csd     (x_csd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
`ifdef CSD2BIN_SEQ_CSD_CHECK_EN
        ,
        .csd_err   (csd_err)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present a word, wait for it to be accepted, then wait for out_valid.
    // lat counts cycles from the accepting edge to out_valid.
    task automatic send(input logic [15:0] x, output int lat, output bit to);
        int n;
        n = 0;
        x_csd    = x;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        to = !out_valid;
    endtask

    task automatic take;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        arst = 1'b1; srst = 1'b0; enable = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; x_csd = '0;
        #12;
        n_tests++;
        if (y !== 8'h00 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: y=%h ovf=%b out_valid=%b in_ready=%b, want y=00 ovf=0 out_valid=0 in_ready=1",
                     y, ovf, out_valid, in_ready);
        end
        arst = 1'b0;
        step();
    endtask

    localparam logic [15:0] VX [8] = '{16'h8001, 16'h8000, 16'h4000, 16'h0021,
                                       16'h5555, 16'hAAAA, 16'h0000, 16'h9000};
    localparam logic [7:0]  VY [8] = '{8'h7F, 8'h80, 8'h80, 8'h03,
                                       8'h01, 8'hFF, 8'h00, 8'h40};
    localparam logic        VO [8] = '{1'b0, 1'b1, 1'b0, 1'b0,
                                       1'b1, 1'b1, 1'b0, 1'b0};

    task automatic test_basic;
        int lat;
        bit to;
        for (int i = 0; i < 8; i++) begin
            send(VX[i], lat, to);
            n_tests++;
            if (to || lat != 4) begin
                n_fail++;
                $display("FAIL basic_latency x=%h: got %0d cycles (timeout=%b), want 4", VX[i], lat, to);
            end
            n_tests++;
            if (y !== VY[i] || ovf !== VO[i]) begin
                n_fail++;
                $display("FAIL basic_value x=%h: got y=%h ovf=%b, want y=%h ovf=%b",
                         VX[i], y, ovf, VY[i], VO[i]);
            end
            take();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        bit to;
        send(16'h0021, lat, to);
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (to || y !== 8'h03 || ovf !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: y=%h ovf=%b in_ready=%b out_valid=%b, want 03 0 0 1",
                         c, y, ovf, in_ready, out_valid);
            end
            step();
        end
        take();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_stall;
        int lat;
        x_csd    = 16'h0021;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        lat = 4;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        n_tests++;
        if (lat != 7 || y !== 8'h03) begin
            n_fail++;
            $display("FAIL stall: latency=%0d y=%h, want 7 and 03", lat, y);
        end
        take();
    endtask

    task automatic test_arst;
        int lat;
        bit to;
        x_csd    = 16'h8001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2;
        arst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 8'h00) begin
            n_fail++;
            $display("FAIL arst_midconv: out_valid=%b in_ready=%b y=%h, want 0 1 00", out_valid, in_ready, y);
        end
        arst = 1'b0;
        step();
        send(16'h8001, lat, to);
        n_tests++;
        if (to || lat != 4 || y !== 8'h7F || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_recover: lat=%0d y=%h ovf=%b, want 4 7f 0", lat, y, ovf);
        end
        take();
    endtask

    task automatic test_srst;
        int lat;
        bit to;
        x_csd    = 16'h4000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 8'h00) begin
            n_fail++;
            $display("FAIL srst_midconv: out_valid=%b in_ready=%b y=%h, want 0 1 00", out_valid, in_ready, y);
        end
        send(16'h0021, lat, to);
        n_tests++;
        if (to || y !== 8'h03) begin
            n_fail++;
            $display("FAIL srst_recover: y=%h timeout=%b, want 03", y, to);
        end
        take();
    endtask

`ifdef CSD2BIN_SEQ_CSD_CHECK_EN
    localparam logic [15:0] CX [3] = '{16'h0003, 16'h000A, 16'h0021};
    localparam logic [7:0]  CY [3] = '{8'h00, 8'h03, 8'h03};
    localparam logic        CE [3] = '{1'b1, 1'b1, 1'b0};

    task automatic test_csd_check;
        int lat;
        bit to;
        for (int i = 0; i < 3; i++) begin
            send(CX[i], lat, to);
            n_tests++;
            if (to || y !== CY[i] || csd_err !== CE[i]) begin
                n_fail++;
                $display("FAIL csd_check x=%h: y=%h csd_err=%b, want y=%h csd_err=%b",
                         CX[i], y, csd_err, CY[i], CE[i]);
            end
            take();
        end
    endtask
`endif

    task automatic test_random;
        logic [15:0] x;
        logic [7:0]  p, n;
        logic [8:0]  d;
        bit          acc, done;
        int          cyc;
        for (int w = 0; w < 1000; w++) begin
            x = 16'($urandom);
            for (int i = 0; i < 8; i++) begin
                p[i] = x[2*i+1];
                n[i] = x[2*i];
            end
            d = {1'b0, p} - {1'b0, n};
            acc = 1'b0; done = 1'b0; cyc = 0;
            x_csd = x;
            in_valid = 1'b1;
            while (!done && cyc < 300) begin
                enable    = ($urandom_range(0, 3) != 0);
                out_ready = 1'($urandom_range(0, 1));
                #1;
                if (in_valid && in_ready) acc = 1'b1;
                if (out_valid && out_ready) begin
                    done = 1'b1;
                    n_tests++;
                    if (y !== d[7:0] || ovf !== (d[8] ^ d[7])) begin
                        n_fail++;
                        $display("FAIL random #%0d x=%h: y=%h ovf=%b, want y=%h ovf=%b",
                                 w, x, y, ovf, d[7:0], d[8] ^ d[7]);
                    end
                end
                @(posedge clk);
                #1;
                if (acc) in_valid = 1'b0;
                cyc++;
            end
            if (!done) begin
                n_tests++;
                n_fail++;
                $display("FAIL random_timeout #%0d x=%h: no output within 300 cycles", w, x);
                in_valid = 1'b0;
            end
        end
        enable    = 1'b1;
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_arst();
        test_srst();
`ifdef CSD2BIN_SEQ_CSD_CHECK_EN
        test_csd_check();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csd2bin_seq.md
Name: csd2bin_seq

Overview:
- Iterative converter from signed-digit (CSD) form to two's-complement binary, with a valid/ready handshake on each side.
- Receiving end of the redundant-number path: takes X/Y results in CSD form from bkm_step and delivers binary words to the FPU output stage.
- Resolves the borrow chain serially, DPC digits per cycle, so no W-bit carry-propagate adder is needed in one cycle.

Parameters:
- W, 8, result width in bits; the input has W signed digits (2*W bits).
- DPC, 2, digits processed per cycle; must divide W exactly.
- LOG2W, 3, ceil(log2(W)); sets the width of the digit counter.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous active-high reset
- srst  in  1  synchronous active-high reset, same effect as arst
- enable  in  1  global advance/stall qualifier
- in_valid  in  1  source has a CSD word
- in_ready  out  1  block can accept a word
- x_csd  in  2*W  digit i is {x_csd[2i+1]=pos, x_csd[2i]=neg}; value d_i = pos - neg; X = sum of d_i*2^i
- out_valid  out  1  result available
- out_ready  in  1  sink accepts the result
- y  out  W  two's-complement result, X mod 2^W
- ovf  out  1  X is outside [-2^(W-1), 2^(W-1)-1]

Behaviour:
- Reset (arst async, or srst at an edge): state=IDLE; y=0, ovf=0, out_valid=0; internal shift registers, borrow and counter cleared. A reset mid-conversion discards the word in flight.
- Every register holds while enable=0.
- Handshakes are gated by enable:
  - in_ready = enable & (state==IDLE)
  - out_valid = enable & (state==DONE)
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- FSM:
  - IDLE: on input transfer, load P = pos bits and N = neg bits (each W bits); borrow=0; cnt=0; go to CONV.
  - CONV: each enabled cycle:
    - compute the low DPC bits of P - N - borrow;
    - shift that slice into the top of the result register;
    - shift P and N right by DPC;
    - update borrow from the slice borrow-out;
    - cnt = cnt + 1.
    - When cnt reaches W/DPC-1, go to DONE; the final borrow gives bit W of the (W+1)-bit difference.
  - DONE: y and ovf hold; ovf = final_borrow XOR y[W-1]. On output transfer, go to IDLE.
- Latency:
  - input transfer at edge k gives out_valid=1 after edge k+W/DPC (W=8, DPC=2: 4 cycles).
  - Throughput is one word per W/DPC+2 cycles.
  - in_ready is low during CONV and DONE, so a new input cannot be accepted in the same cycle as an output transfer.
- Backpressure: DONE may be held indefinitely; y and ovf stay stable while out_ready=0.
- Digit code 11 (pos=neg=1) is treated as value 0 by the arithmetic.
- y and ovf are don't-care outside DONE but must not change except when a conversion completes or on reset.

Optional Feature:
- Macro: CSD2BIN_SEQ_CSD_CHECK_EN.
- Defined:
  - Adds output port csd_err (1 bit, reset 0).
  - At input transfer, csd_err is computed from x_csd and registered. It is 1 if any digit has code 11, or if any two adjacent digits are both nonzero (the input is not canonical).
  - csd_err is valid and stable in DONE alongside y.
  - The arithmetic result is unaffected.
- Undefined: port and logic are absent; non-canonical input converts silently.

Test Plan (W=8, DPC=2):
- x_csd=16'h8001 (d7=+1, d0=-1): result 127 -> y=8'h7F, ovf=0, out_valid 4 cycles after input transfer.
- x_csd=16'h8000 (d7=+1): result 128 -> y=8'h80, ovf=1; x_csd=16'h4000 (d7=-1): result -128 -> y=8'h80, ovf=0.
- x_csd=16'h0021 (d2=+1, d0=-1): y=8'h03, ovf=0. Then hold out_ready=0 for 10 cycles: y stays stable, in_ready=0; release out_ready: IDLE the next cycle.
- Stall/reset:
  - Toggle enable=0 for 3 cycles mid-CONV on 16'h0021: completion slips by exactly 3 cycles and y=8'h03.
  - Assert arst mid-CONV: out_valid=0, in_ready=1 (enable=1) immediately; the next word converts correctly.
- With CSD2BIN_SEQ_CSD_CHECK_EN:
  - 16'h0003 gives y=0, csd_err=1.
  - 16'h000A (d1=d0=+1) gives y=8'h03, csd_err=1.
  - 16'h0021 gives csd_err=0.
- Random: 1000 random x_csd words with random out_ready/enable gaps; each y and ovf compared against the reference model P-N computed in W+1 bits.
